serial_frame_tx: RTL and testbench

//  Transmit side of the lab serial-frame link: sends a fixed preamble, then a payload word MSB-first on one wire.
//  The Detector/Counter pair on the receive end finds the preamble, then passes exactly PAYLOAD_BITS bits to SerOut.

---
 rtl/dld_serial_pkg.sv | 23 ++
 rtl/serial_frame_tx_if.sv | 28 ++
 rtl/serial_frame_tx_bit_counter.sv | 31 +++
 rtl/serial_frame_tx.sv | 138 +++++++++++++
 tb/tb_serial_frame_tx.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/dld_serial_pkg.sv
// Shared types and defaults for the lab serial-frame link.
//   tx_state_t  : transmitter FSM states
//   *_DEF       : default frame parameters (must match the receive-side Detector/Counter)
//   cnt_width() : bit-counter width able to count the longest frame phase without wrapping
package dld_serial_pkg;

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_PAY, S_GUARD} tx_state_t;

  localparam logic [3:0] PREAMBLE_DEF     = 4'b1101;
  localparam int         PAYLOAD_BITS_DEF = 16;
  localparam int         PRE_W_DEF        = 4;
  localparam int         GUARD_BITS_DEF   = 2;

  // $clog2 of the longest phase, plus one bit of headroom.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/serial_frame_tx_if.sv
// Handshake and serial-line bundle of serial_frame_tx.
//   start, data            : frame request and payload word (master -> slave)
//   ready                  : transmitter idle, a request will be accepted
//   ser_out, ser_out_valid : serial line and payload-bit qualifier
//   done                   : one-cycle end-of-frame pulse
// master = requester / line observer, slave = the transmitter.
interface serial_frame_tx_if #(
  parameter int PAYLOAD_BITS = 16
) ();

  logic                    start;
  logic [PAYLOAD_BITS-1:0] data;
  logic                    ready;
  logic                    ser_out;
  logic                    ser_out_valid;
  logic                    done;

  modport master (
    output start, data,
    input  ready, ser_out, ser_out_valid, done
  );

  modport slave (
    input  start, data,
    output ready, ser_out, ser_out_valid, done
  );

endinterface

// File: rtl/serial_frame_tx_bit_counter.sv
// Phase bit counter for serial_frame_tx.
//   clk, rst : clock, asynchronous active-low reset
//   en_i     : clock enable; counter holds when low
//   clr_i    : synchronous clear (takes effect on an enabled edge)
//   tc_val_i : terminal-count compare value for the current phase
//   cnt_o    : current count
//   tc_o     : cnt_o equals tc_val_i
module tx_bit_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic [W-1:0] tc_val_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       cnt_q <= '0;
    else if (en_i)  cnt_q <= clr_i ? '0 : cnt_q + 1'b1;
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == tc_val_i);

endmodule

// File: rtl/serial_frame_tx.sv
// Serial-frame transmitter: preamble, then PAYLOAD_BITS payload bits MSB-first,
// then GUARD_BITS forced zeros. All outputs are registered.
//   clk    : rising-edge clock
//   rst    : asynchronous active-low reset
//   clk_en : clock enable shared with the receiver; low freezes all state
//   bus    : slave side of serial_frame_tx_if (start/data/ready/ser_out/ser_out_valid/done)
module serial_frame_tx
  import dld_serial_pkg::*;
#(
  parameter int             PRE_W        = PRE_W_DEF,
  parameter logic [PRE_W-1:0] PREAMBLE   = PREAMBLE_DEF,
  parameter int             PAYLOAD_BITS = PAYLOAD_BITS_DEF,
  parameter int             GUARD_BITS   = GUARD_BITS_DEF   // must be >= 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  serial_frame_tx_if.slave  bus
);

  localparam int CNT_W = cnt_width(PRE_W, PAYLOAD_BITS, GUARD_BITS);

  tx_state_t               state_q, state_d;
  logic [PAYLOAD_BITS-1:0] shreg_q, shreg_d;
  logic                    ser_out_q, ser_out_d;
  logic                    valid_q, valid_d;
  logic                    ready_q, ready_d;
  logic                    done_q, done_d;

  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        tc_val;
  logic                    cnt_tc;
  logic                    cnt_clr;
  logic [PRE_W-1:0]        pre_rest;

  // cnt indexes the bit currently on the line, so the registered output must be
  // loaded with the *next* preamble bit: shift the pattern by cnt+1, take its MSB.
  assign pre_rest = PREAMBLE << (cnt + 1'b1);

  always_comb begin
    tc_val = '0;
    case (state_q)
      S_PRE:   tc_val = CNT_W'(PRE_W - 1);
      S_PAY:   tc_val = CNT_W'(PAYLOAD_BITS - 1);
      S_GUARD: tc_val = CNT_W'(GUARD_BITS - 1);
      default: tc_val = '0;
    endcase
  end

  tx_bit_counter #(.W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .en_i     (clk_en),
    .clr_i    (cnt_clr),
    .tc_val_i (tc_val),
    .cnt_o    (cnt),
    .tc_o     (cnt_tc)
  );

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    ser_out_d = 1'b0;
    valid_d   = 1'b0;
    ready_d   = 1'b0;
    done_d    = 1'b0;
    cnt_clr   = 1'b0;

    case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        cnt_clr = 1'b1;
        if (bus.start) begin
          state_d   = S_PRE;
          shreg_d   = bus.data;
          ser_out_d = PREAMBLE[PRE_W-1];
          ready_d   = 1'b0;
        end
      end
      S_PRE: begin
        if (cnt_tc) begin
          state_d   = S_PAY;
          cnt_clr   = 1'b1;
          ser_out_d = shreg_q[PAYLOAD_BITS-1];
          shreg_d   = shreg_q << 1;
          valid_d   = 1'b1;
        end else begin
          ser_out_d = pre_rest[PRE_W-1];
        end
      end
      S_PAY: begin
        if (cnt_tc) begin
          state_d = S_GUARD;
          cnt_clr = 1'b1;
        end else begin
          ser_out_d = shreg_q[PAYLOAD_BITS-1];
          shreg_d   = shreg_q << 1;
          valid_d   = 1'b1;
        end
      end
      S_GUARD: begin
        if (cnt_tc) begin
          state_d = S_IDLE;
          cnt_clr = 1'b1;
          done_d  = 1'b1;
          ready_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: the payload shift register is a plain flop bank, so it is reset along with the FSM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      shreg_q   <= '0;
      ser_out_q <= 1'b0;
      valid_q   <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
    end else if (clk_en) begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      ser_out_q <= ser_out_d;
      valid_q   <= valid_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
    end
  end

  assign bus.ready         = ready_q;
  assign bus.ser_out       = ser_out_q;
  assign bus.ser_out_valid = valid_q;
  assign bus.done          = done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Self-checking bench for serial_frame_tx. The expected line for a frame is
// built from the frame rules (preamble, payload MSB-first, guard zeros); a
// receive-side view reassembles the payload from valid-qualified bits.
module tb_serial_frame_tx;

  localparam int PRE_W = 4;
  localparam int PB    = 16;
  localparam int GB    = 2;
  localparam int FRAME = PRE_W + PB + GB;
  localparam logic [PRE_W-1:0] PRE = 4'b1101;

  logic clk    = 1'b0;
  logic rst    = 1'b0;
  logic clk_en = 1'b1;

  always #5 clk = ~clk;

  serial_frame_tx_if #(.PAYLOAD_BITS(PB)) bus ();

  serial_frame_tx #(
    .PRE_W        (PRE_W),
    .PREAMBLE     (PRE),
    .PAYLOAD_BITS (PB),
    .GUARD_BITS   (GB)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .bus    (bus)
  );

  int   checks   = 0;
  int   failures = 0;
  logic exp_line  [FRAME];
  logic exp_valid [FRAME];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference frame: what the line must carry in the cycles after accept.
  function automatic void build_model(input logic [PB-1:0] d);
    logic [PRE_W-1:0] p;
    p = PRE;
    for (int i = 0; i < FRAME; i++) begin
      if (i < PRE_W) begin
        exp_line[i]  = p[PRE_W-1-i];
        exp_valid[i] = 1'b0;
      end else if (i < PRE_W + PB) begin
        exp_line[i]  = d[PB-1-(i-PRE_W)];
        exp_valid[i] = 1'b1;
      end else begin
        exp_line[i]  = 1'b0;
        exp_valid[i] = 1'b0;
      end
    end
  endfunction

  task automatic do_accept(input logic [PB-1:0] d, input bit hold);
    bus.data  = d;
    bus.start = 1'b1;
    check("ready_before_accept", bus.ready, 1);
    step();
    if (!hold) bus.start = 1'b0;
    bus.data = PB'($urandom);
  endtask

  // Walks one frame starting just after the accept edge. Optional clk_en stall
  // at bit stall_idx for stall_len edges, optional start pulse at bit ign_idx.
  task automatic check_frame(input logic [PB-1:0] d, input int stall_idx,
                             input int stall_len, input int ign_idx, input string tag);
    logic [PB-1:0] rx;
    int            vcnt;
    rx   = '0;
    vcnt = 0;
    build_model(d);
    for (int i = 0; i < FRAME; i++) begin
      check($sformatf("%s_line%0d", tag, i), bus.ser_out, exp_line[i]);
      check($sformatf("%s_valid%0d", tag, i), bus.ser_out_valid, exp_valid[i]);
      check($sformatf("%s_ready%0d", tag, i), bus.ready, 0);
      check($sformatf("%s_done%0d", tag, i), bus.done, 0);
      if (bus.ser_out_valid === 1'b1) begin
        rx = {rx[PB-2:0], bus.ser_out};
        vcnt++;
      end
      if (i == stall_idx) begin
        clk_en = 1'b0;
        repeat (stall_len) begin
          step();
          check($sformatf("%s_stall_line%0d", tag, i), bus.ser_out, exp_line[i]);
          check($sformatf("%s_stall_valid%0d", tag, i), bus.ser_out_valid, exp_valid[i]);
        end
        clk_en = 1'b1;
      end
      if (i == ign_idx) begin
        bus.start = 1'b1;
        bus.data  = ~d;
      end
      step();
      if (i == ign_idx) bus.start = 1'b0;
    end
    check($sformatf("%s_rx_word", tag), rx, d);
    check($sformatf("%s_valid_count", tag), vcnt, PB);
    check($sformatf("%s_done_end", tag), bus.done, 1);
    check($sformatf("%s_ready_end", tag), bus.ready, 1);
    check($sformatf("%s_line_end", tag), bus.ser_out, 0);
    check($sformatf("%s_valid_end", tag), bus.ser_out_valid, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [PB-1:0] d;
    bus.start = 1'b0;
    bus.data  = '0;

    // Reset state
    repeat (2) step();
    check("rst_line", bus.ser_out, 0);
    check("rst_valid", bus.ser_out_valid, 0);
    check("rst_ready", bus.ready, 1);
    check("rst_done", bus.done, 0);
    rst = 1'b1;
    step();

    // Single frame; done must also hold across a disabled edge
    do_accept(16'hA5C3, 1'b0);
    check_frame(16'hA5C3, -1, 0, -1, "single");
    clk_en = 1'b0;
    step();
    check("done_hold_clken0", bus.done, 1);
    clk_en = 1'b1;
    step();
    check("done_cleared", bus.done, 0);
    check("idle_ready", bus.ready, 1);
    check("idle_line", bus.ser_out, 0);

    // Back-to-back with start held high
    bus.data  = 16'hFFFF;
    bus.start = 1'b1;
    check("b2b_ready_first", bus.ready, 1);
    step();
    bus.data = 16'h0000;
    check_frame(16'hFFFF, -1, 0, -1, "b2b1");
    step();
    check_frame(16'h0000, -1, 0, -1, "b2b2");
    bus.start = 1'b0;
    step();
    check("b2b_idle_ready", bus.ready, 1);
    check("b2b_idle_done", bus.done, 0);
    check("b2b_idle_line", bus.ser_out, 0);

    // Stall: payload bit 5 held for 3 extra cycles
    d = PB'($urandom);
    do_accept(d, 1'b0);
    check_frame(d, PRE_W + 5, 3, -1, "stall");

    // Asynchronous reset during the preamble, then a clean frame
    d = PB'($urandom);
    do_accept(d, 1'b0);
    check("abort_pre0", bus.ser_out, 1);
    step();
    check("abort_pre1", bus.ser_out, 1);
    #2;
    rst = 1'b0;
    #1;
    check("abort_line", bus.ser_out, 0);
    check("abort_valid", bus.ser_out_valid, 0);
    check("abort_ready", bus.ready, 1);
    check("abort_done", bus.done, 0);
    step();
    rst = 1'b1;
    step();
    check("abort_idle_line", bus.ser_out, 0);
    d = PB'($urandom);
    do_accept(d, 1'b0);
    check_frame(d, -1, 0, -1, "post_rst");

    // Start pulsed during payload is ignored and not queued
    step();
    d = PB'($urandom);
    do_accept(d, 1'b0);
    check_frame(d, -1, 0, PRE_W + 3, "ign");
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("ign_noq_line%0d", k), bus.ser_out, 0);
      check($sformatf("ign_noq_ready%0d", k), bus.ready, 1);
      check($sformatf("ign_noq_valid%0d", k), bus.ser_out_valid, 0);
    end

    // Randomized frames with random stalls
    for (int k = 0; k < 4; k++) begin
      d = PB'($urandom);
      do_accept(d, 1'b0);
      check_frame(d, int'($urandom_range(0, FRAME - 1)), int'($urandom_range(0, 3)), -1,
                  $sformatf("rnd%0d", k));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
